// File: rtl/sha256_core_arbiter.sv
// ============================================================================
// sha256_core_arbiter
// ----------------------------------------------------------------------------
// Shares one sha256_v2 hashing core between NUM_REQ message requesters. Only
// one requester owns the core at a time. The owner streams each 512-bit block
// as 16 words into a local 16x32 buffer. The arbiter then bursts the buffer
// into the core over 16 back-to-back write cycles and waits for the core to
// finish compressing before it accepts the next block. After the last block
// the core pads the message and steps through its READ phase by itself. The
// eight digest words are captured here and returned as one 256-bit digest.
//
// Parameters
//   NUM_REQ  number of requesters (2..8)
//   ID_W     requester-id width, clog2(NUM_REQ)
//
// Ports
//   i_clk          clock, all logic on the rising edge
//   i_rst          asynchronous active-low reset (also resets the core)
//   i_req          per-requester request level, held until its digest is taken
//   i_req_nblk     per-requester block count N, slice k belongs to requester k
//   i_req_bitmiss  per-requester missing-bit count for the last block
//   o_grant        one-hot owner, zero when idle or cooling down
//   i_wvalid       message word valid from the owner
//   i_wdata        message word, big-endian word order within a block
//   o_wready       buffer can take a word (only while filling)
//   o_dig_valid    digest valid, held until i_dig_ready
//   i_dig_ready    digest accepted
//   o_digest       {H0..H7}, H0 in [255:224]
//   o_dig_id       owner id belonging to o_digest
//   o_err          one-cycle pulse when the granted request had N == 0
//   o_core_write   core i_write
//   o_core_data    core i_data
//   o_core_N       core i_N, held for the whole job
//   o_core_bitmiss core i_bit_miss, held for the whole job
//   i_core_data    core o_data
//   i_core_done    core o_done
//   i_core_read    core o_read (READ-phase word index, 1..8)
//
// Configuration
//   SHA_ARB_FIXED_PRIO_EN  when defined, arbitration is fixed priority and the
//                          lowest requester index wins. When undefined (the
//                          default), arbitration is round-robin and starts
//                          after the last owner.
// ============================================================================
module sha256_core_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [8*NUM_REQ-1:0] i_req_nblk,
    input  logic [9*NUM_REQ-1:0] i_req_bitmiss,
    output logic [NUM_REQ-1:0]   o_grant,
    input  logic                 i_wvalid,
    input  logic [31:0]          i_wdata,
    output logic                 o_wready,
    output logic                 o_dig_valid,
    input  logic                 i_dig_ready,
    output logic [255:0]         o_digest,
    output logic [ID_W-1:0]      o_dig_id,
    output logic                 o_err,
    output logic                 o_core_write,
    output logic [31:0]          o_core_data,
    output logic [7:0]           o_core_N,
    output logic [8:0]           o_core_bitmiss,
    input  logic [31:0]          i_core_data,
    input  logic                 i_core_done,
    input  logic [3:0]           i_core_read
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_FILL,
        S_BURST,
        S_WAIT_ACK,
        S_WAIT_DIG,
        S_RESP,
        S_COOL
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ID_W-1:0]   owner;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_idx;
    logic [ID_W-1:0]   cand;
    logic              win_found;

    logic [7:0]        blk_cnt;
    logic [4:0]        buf_cnt;
    logic [3:0]        burst_idx;
    logic [31:0]       blk_buf [16];

    logic              done_low_seen;
    logic [3:0]        read_q;
    logic [31:0]       dig_words [8];
    logic              cool_cnt;

    logic              last_blk;
    logic              cap_word;
    logic              start_job;

    assign last_blk  = (blk_cnt == (o_core_N - 8'd1));
    // The core presents the word for index k one cycle after it shows k on
    // o_read, so the registered index selects the digest slot.
    assign cap_word  = (read_q != 4'd0) && (read_q <= 4'd8);
    assign start_job = win_found && i_core_done;

    assign o_digest  = {dig_words[0], dig_words[1], dig_words[2], dig_words[3],
                        dig_words[4], dig_words[5], dig_words[6], dig_words[7]};
    assign o_dig_id  = owner;

    // Winner selection. In round-robin mode rr_ptr holds the first candidate
    // to consider, which is one past the previous owner. Scanning from the
    // highest offset down lets the nearest requester win.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
`ifdef SHA_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'(i);
            if (i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. This block also drives the outputs that follow
    // directly from the current state.
    always_comb begin
        state_nxt    = state;
        o_wready     = 1'b0;
        o_core_write = 1'b0;
        o_core_data  = 32'd0;
        o_dig_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_job) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                state_nxt = (o_core_N == 8'd0) ? S_COOL : S_FILL;
            end
            S_FILL: begin
                o_wready = (buf_cnt < 5'd16);
                if (buf_cnt == 5'd16) begin
                    state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                o_core_write = 1'b1;
                o_core_data  = blk_buf[burst_idx];
                if (burst_idx == 4'd15) begin
                    state_nxt = last_blk ? S_WAIT_DIG : S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                // Wait for the low-then-high edge on done. A done level that
                // is still high from the previous block must not count.
                if (done_low_seen && i_core_done) begin
                    state_nxt = S_FILL;
                end
            end
            S_WAIT_DIG: begin
                if (read_q == 4'd8) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                o_dig_valid = 1'b1;
                if (i_dig_ready) begin
                    state_nxt = S_COOL;
                end
            end
            S_COOL: begin
                if (cool_cnt) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: job parameters, block buffer, block and burst counters,
    // digest capture and the round-robin pointer.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            owner          <= '0;
            rr_ptr         <= '0;
            o_grant        <= '0;
            o_core_N       <= 8'd0;
            o_core_bitmiss <= 9'd0;
            o_err          <= 1'b0;
            blk_cnt        <= 8'd0;
            buf_cnt        <= 5'd0;
            burst_idx      <= 4'd0;
            done_low_seen  <= 1'b0;
            read_q         <= 4'd0;
            cool_cnt       <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                blk_buf[i] <= 32'd0;
            end
            for (int i = 0; i < 8; i++) begin
                dig_words[i] <= 32'd0;
            end
        end else begin
            read_q <= i_core_read;
            o_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_job) begin
                        owner          <= win_idx;
                        o_grant        <= NUM_REQ'(1) << win_idx;
                        o_core_N       <= i_req_nblk[int'(win_idx) * 8 +: 8];
                        o_core_bitmiss <= i_req_bitmiss[int'(win_idx) * 9 +: 9];
                    end
                end
                S_GRANT: begin
                    blk_cnt <= 8'd0;
                    buf_cnt <= 5'd0;
                    if (o_core_N == 8'd0) begin
                        o_err    <= 1'b1;
                        o_grant  <= '0;
                        cool_cnt <= 1'b0;
                    end
                end
                S_FILL: begin
                    burst_idx <= 4'd0;
                    if (i_wvalid && o_wready) begin
                        blk_buf[buf_cnt[3:0]] <= i_wdata;
                        buf_cnt               <= buf_cnt + 5'd1;
                    end
                end
                S_BURST: begin
                    burst_idx <= burst_idx + 4'd1;
                    if (burst_idx == 4'd15) begin
                        buf_cnt       <= 5'd0;
                        done_low_seen <= 1'b0;
                        if (!last_blk) begin
                            blk_cnt <= blk_cnt + 8'd1;
                        end
                    end
                end
                S_WAIT_ACK: begin
                    if (!i_core_done) begin
                        done_low_seen <= 1'b1;
                    end
                end
                S_WAIT_DIG: begin
                    if (cap_word) begin
                        dig_words[3'(read_q - 4'd1)] <= i_core_data;
                    end
                end
                S_RESP: begin
                    if (i_dig_ready) begin
                        o_grant  <= '0;
                        cool_cnt <= 1'b0;
                    end
                end
                S_COOL: begin
                    // The two idle cycles let the core return from READ to IDLE.
                    cool_cnt <= 1'b1;
                    if (cool_cnt) begin
                        rr_ptr <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// ============================================================================
// tb_sha256_core_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for sha256_core_arbiter. A behavioural stand-in for the
// sha256_v2 core works on the falling clock edge. It counts 16-word blocks,
// drops done while it compresses and, after block N, walks o_read through
// 1..8 while it returns preset digest words one cycle behind the index.
// Jobs come from a table. Hand-written sequences cover the request-all
// ordering and the reset state.
// Macro: SHA_ARB_FIXED_PRIO_EN selects fixed-priority expectations.
// ============================================================================
module tb_sha256_core_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   i_req = '0;
    logic [8*NUM_REQ-1:0] i_req_nblk = '0;
    logic [9*NUM_REQ-1:0] i_req_bitmiss = '0;
    logic [NUM_REQ-1:0]   o_grant;
    logic                 i_wvalid = 1'b0;
    logic [31:0]          i_wdata = '0;
    logic                 o_wready;
    logic                 o_dig_valid;
    logic                 i_dig_ready = 1'b0;
    logic [255:0]         o_digest;
    logic [ID_W-1:0]      o_dig_id;
    logic                 o_err;
    logic                 o_core_write;
    logic [31:0]          o_core_data;
    logic [7:0]           o_core_N;
    logic [8:0]           o_core_bitmiss;
    logic [31:0]          core_data;
    logic                 core_done;
    logic [3:0]           core_read;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_cnt = 0;

    logic [31:0] core_h [8];
    int          core_wcnt;
    int          core_blks;
    int          core_busy;
    int          core_rd;

    logic [31:0] wr_data [$];
    int          wr_cyc  [$];
    logic [31:0] sent    [$];

    typedef struct {
        int           id;
        logic [7:0]   nblk;
        logic [8:0]   bitmiss;
        logic [31:0]  w0;
        logic [255:0] dig;
        bit           toggle;
        int           hold;
        int           other;
    } job_t;

    job_t jobs [4];

    sha256_core_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_clk          (clk),
        .i_rst          (rst_n),
        .i_req          (i_req),
        .i_req_nblk     (i_req_nblk),
        .i_req_bitmiss  (i_req_bitmiss),
        .o_grant        (o_grant),
        .i_wvalid       (i_wvalid),
        .i_wdata        (i_wdata),
        .o_wready       (o_wready),
        .o_dig_valid    (o_dig_valid),
        .i_dig_ready    (i_dig_ready),
        .o_digest       (o_digest),
        .o_dig_id       (o_dig_id),
        .o_err          (o_err),
        .o_core_write   (o_core_write),
        .o_core_data    (o_core_data),
        .o_core_N       (o_core_N),
        .o_core_bitmiss (o_core_bitmiss),
        .i_core_data    (core_data),
        .i_core_done    (core_done),
        .i_core_read    (core_read)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the core. It changes its outputs on the falling edge, so
    // the arbiter always samples stable values on the rising edge.
    assign core_read = (core_rd >= 1 && core_rd <= 8) ? 4'(core_rd) : 4'd0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_done <= 1'b1;
            core_wcnt <= 0;
            core_blks <= 0;
            core_busy <= 0;
            core_rd   <= 0;
            core_data <= 32'd0;
        end else if (o_core_write) begin
            if (core_wcnt == 15) begin
                core_wcnt <= 0;
                core_blks <= core_blks + 1;
                core_done <= 1'b0;
                core_busy <= 6;
            end else begin
                core_wcnt <= core_wcnt + 1;
            end
        end else if (core_busy > 0) begin
            core_busy <= core_busy - 1;
            if (core_busy == 1) begin
                if (core_blks == int'(o_core_N)) core_rd <= 1;
                else core_done <= 1'b1;
            end
        end else if (core_rd > 0) begin
            if (core_rd <= 8) begin
                core_data <= core_h[core_rd-1];
                core_rd   <= core_rd + 1;
            end else begin
                core_rd   <= 0;
                core_done <= 1'b1;
                core_blks <= 0;
            end
        end
    end

    // Monitors for core writes and error pulses.
    always @(negedge clk) begin
        if (rst_n && o_core_write) begin
            wr_data.push_back(o_core_data);
            wr_cyc.push_back(cyc);
        end
        if (rst_n && o_err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        i_req = '0;
        i_wvalid = 1'b0;
        i_dig_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic feedWords(input int total, input bit toggle, input int id, input logic [31:0] w0);
        int  idx = 0;
        int  guard = 0;
        bit  phase = 1'b0;
        while (idx < total && guard < 3000) begin
            @(negedge clk);
            if (toggle && phase) begin
                i_wvalid = 1'b0;
            end else begin
                i_wvalid = 1'b1;
                i_wdata  = (idx == 0) ? w0 : (32'h01000000 * (id + 1) + 32'(idx));
            end
            phase = ~phase;
            #1;
            if (i_wvalid && o_wready) begin
                sent.push_back(i_wdata);
                idx++;
            end
            guard++;
        end
        @(negedge clk);
        i_wvalid = 1'b0;
        checkOutput("feed_done", idx, total);
    endtask

    task automatic applyStimulus(input job_t j, input int exp_owner, input bit drop);
        int           waited;
        int           mism;
        int           gaps;
        int           base;
        bit           stable;
        logic [255:0] seen;
        for (int k = 0; k < 8; k++) core_h[k] = j.dig[255-32*k -: 32];
        i_req_nblk[j.id*8 +: 8]    = j.nblk;
        i_req_bitmiss[j.id*9 +: 9] = j.bitmiss;
        i_req[j.id] = 1'b1;
        wr_data.delete();
        wr_cyc.delete();
        sent.delete();
        base = err_cnt;
        waited = 0;
        @(negedge clk);
        while (o_grant == '0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("grant", o_grant, 256'(1) << exp_owner);
        checkOutput("core_N", o_core_N, j.nblk);
        checkOutput("core_bitmiss", o_core_bitmiss, j.bitmiss);
        if (j.nblk == 8'd0) begin
            i_req[j.id] = 1'b0;
            repeat (6) @(negedge clk);
            checkOutput("err_pulses", err_cnt - base, 1);
            checkOutput("err_no_writes", wr_data.size(), 0);
            checkOutput("err_grant_drop", o_grant, 0);
        end else begin
            feedWords(16 * int'(j.nblk), j.toggle, j.id, j.w0);
            waited = 0;
            while (!o_dig_valid && waited < 1000) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("dig_valid", o_dig_valid, 1);
            checkOutput("digest", o_digest, j.dig);
            checkOutput("dig_id", o_dig_id, exp_owner);
            checkOutput("write_count", wr_data.size(), 16 * int'(j.nblk));
            mism = 0;
            for (int k = 0; k < wr_data.size() && k < sent.size(); k++)
                if (wr_data[k] !== sent[k]) mism++;
            checkOutput("burst_data", mism, 0);
            gaps = 0;
            for (int k = 1; k < wr_cyc.size(); k++) begin
                if ((k % 16) != 0 && wr_cyc[k] - wr_cyc[k-1] != 1) gaps++;
                if ((k % 16) == 0 && wr_cyc[k] - wr_cyc[k-1] <= 1) gaps++;
            end
            checkOutput("burst_windows", gaps, 0);
            if (j.other >= 0) i_req[j.other] = 1'b1;
            stable = 1'b1;
            seen = o_digest;
            for (int c = 0; c < j.hold; c++) begin
                @(negedge clk);
                if (o_digest !== seen || !o_dig_valid || o_grant !== NUM_REQ'(1 << exp_owner))
                    stable = 1'b0;
            end
            if (j.hold > 0) checkOutput("hold_stable", stable, 1);
            i_dig_ready = 1'b1;
            if (drop) i_req[j.id] = 1'b0;
            @(negedge clk);
            i_dig_ready = 1'b0;
            if (j.other >= 0) i_req[j.other] = 1'b0;
            checkOutput("dig_released", o_dig_valid, 0);
        end
    endtask

    initial begin
        job_t rr;
        int   exp_id;
        jobs[0] = '{0, 8'd1, 9'd488, 32'h61626300,
                    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad,
                    1'b0, 0, -1};
        jobs[1] = '{1, 8'd2, 9'd64, 32'h31323334,
                    256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888,
                    1'b0, 0, -1};
        jobs[2] = '{2, 8'd0, 9'd0, 32'h0,
                    256'h0, 1'b0, 0, -1};
        jobs[3] = '{3, 8'd1, 9'd100, 32'hdeadbeef,
                    256'hcafef00d_01234567_89abcdef_0f0f0f0f_f0f0f0f0_a5a5a5a5_5a5a5a5a_13579bdf,
                    1'b1, 20, 0};

        doReset();
        checkOutput("rst_grant", o_grant, 0);
        checkOutput("rst_wready", o_wready, 0);
        checkOutput("rst_core_write", o_core_write, 0);
        checkOutput("rst_dig_valid", o_dig_valid, 0);
        checkOutput("rst_err", o_err, 0);
        checkOutput("rst_digest", o_digest, 0);
        checkOutput("rst_core_N", o_core_N, 0);
        checkOutput("rst_dig_id", o_dig_id, 0);

        for (int t = 0; t < 4; t++) begin
            $display("[TB] job %0d requester %0d", t, jobs[t].id);
            applyStimulus(jobs[t], jobs[t].id, 1'b1);
        end

        // All four requesters hold their requests. Each job must go to the
        // next owner in turn, or always to requester 0 under fixed priority.
        doReset();
        i_req_nblk = {NUM_REQ{8'd1}};
        i_req_bitmiss = {NUM_REQ{9'd7}};
        i_req = '1;
        for (int r = 0; r < 5; r++) begin
`ifdef SHA_ARB_FIXED_PRIO_EN
            exp_id = 0;
`else
            exp_id = r % NUM_REQ;
`endif
            rr = '{exp_id, 8'd1, 9'd7, 32'h00a0b0c0 + 32'(r),
                   {8{32'h10000000 * 32'(r + 1) + 32'(exp_id)}}, 1'b0, 0, -1};
            applyStimulus(rr, exp_id, r == 4);
        end
        i_req = '0;
        repeat (4) @(negedge clk);
        checkOutput("final_idle_grant", o_grant, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
